phy_link_ctrl: RTL and testbench

Link bring-up and supervision controller for the phy transmitter/receiver pair, clocked in the parallel byte domain (clk_4f).
- Forces the transmitter to send the BC comma byte until the receiver reports a stable run of BC bytes, then declares the link up and lets lane data through.
- Monitors receiver coding errors and retrains on persistent errors or on request.
- Sits between the lane-level logic and the phy_tx/phy_rx pair; it gates tx data and does not touch the serial path.

---
 rtl/phy_link_ctrl_pkg.sv | 20 ++
 rtl/phy_link_ctrl_if.sv | 28 ++
 rtl/phy_link_ctrl_timer.sv | 38 +++
 rtl/phy_link_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_phy_link_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phy_link_ctrl_pkg.sv
// Shared definitions for the phy link bring-up controller: state
// encodings, the default comma byte and the counter sizing helper.
package phy_link_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_TRAIN   = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_RETRAIN = 3'd3,
        ST_FAIL    = 3'd4
    } link_state_e;

    localparam logic [7:0] BC_BYTE_DEF = 8'hBC;

    // Width of a counter that must be able to hold the value v.
    function automatic int cnt_w(input int v);
        return $clog2(v) + 1;
    endfunction

endpackage

// File: rtl/phy_link_ctrl_if.sv
// Lane-side view of the link controller: receiver status in, transmitter
// gating and link status out. The controller takes the slave side.
interface phy_link_ctrl_if;

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_err;
    logic       tx_pending;
    logic       retrain_req;

    logic       tx_send_bc;
    logic       tx_enable;
    logic       link_up;
    logic       link_fail;
    logic [2:0] state;
    logic [7:0] retrain_cnt;

    modport master (
        output rx_byte, rx_byte_valid, rx_err, tx_pending, retrain_req,
        input  tx_send_bc, tx_enable, link_up, link_fail, state, retrain_cnt
    );

    modport slave (
        input  rx_byte, rx_byte_valid, rx_err, tx_pending, retrain_req,
        output tx_send_bc, tx_enable, link_up, link_fail, state, retrain_cnt
    );

endinterface

// File: rtl/phy_link_ctrl_timer.sv
// Loadable down-counter shared by the TRAIN timeout, RETRAIN hold and
// FAIL wait. done_o marks the edge on which the loaded interval ends.
module phy_link_ctrl_timer #(
    parameter int W = 8
) (
    input  logic         clk_4f,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of N makes the N-th following edge the final one.
    assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/phy_link_ctrl.sv
// Link bring-up and supervision FSM in the clk_4f byte domain. Forces BC
// on the transmitter until the receiver sees a run of clean BC bytes,
// then opens the lane; retrains on persistent coding errors or request.
module phy_link_ctrl
    import phy_link_ctrl_pkg::*;
#(
    parameter logic [7:0] BC_BYTE    = BC_BYTE_DEF,
    parameter int         LOCK_CNT   = 4,
    parameter int         TIMEOUT    = 255,
    parameter int         ERR_MAX    = 4,
    parameter int         HOLD_CYC   = 8,
    parameter int         RETRY_WAIT = 64
) (
    input logic             clk_4f,
    input logic             reset,
    phy_link_ctrl_if.slave  link
);

    localparam int BC_W    = cnt_w(LOCK_CNT);
    localparam int ERR_W   = cnt_w(ERR_MAX);
    localparam int TMR_MAX = (TIMEOUT > RETRY_WAIT)
                           ? ((TIMEOUT > HOLD_CYC) ? TIMEOUT : HOLD_CYC)
                           : ((RETRY_WAIT > HOLD_CYC) ? RETRY_WAIT : HOLD_CYC);
    localparam int TMR_W   = cnt_w(TMR_MAX);

    localparam logic [BC_W-1:0]  LOCK_V = BC_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_V  = ERR_W'(ERR_MAX);

    link_state_e      state_q, state_d;
    logic [BC_W-1:0]  bc_cnt_q, bc_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       retrain_cnt_q, retrain_cnt_d;
    logic             tx_send_bc_q, tx_send_bc_d;
    logic             tx_enable_q, tx_enable_d;
    logic             link_up_q, link_up_d;
    logic             link_fail_q, link_fail_d;

    logic             restart;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    logic             good_bc;
    logic             err_byte;
    logic [BC_W-1:0]  bc_inc;
    logic [ERR_W-1:0] err_inc;

    assign good_bc  = link.rx_byte_valid && !link.rx_err && (link.rx_byte == BC_BYTE);
    assign err_byte = link.rx_byte_valid && link.rx_err;
    assign bc_inc   = bc_cnt_q + BC_W'(1);
    assign err_inc  = err_cnt_q + ERR_W'(1);

    phy_link_ctrl_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Next state, counters, timer reload and registered output values.
    always_comb begin
        state_d       = state_q;
        bc_cnt_d      = bc_cnt_q;
        err_cnt_d     = err_cnt_q;
        retrain_cnt_d = retrain_cnt_q;
        restart       = 1'b0;
        tmr_load      = 1'b0;
        tmr_val       = '0;
        tx_send_bc_d  = 1'b1;
        tx_enable_d   = 1'b0;
        link_up_d     = 1'b0;
        link_fail_d   = 1'b0;

        case (state_q)
            ST_RST: begin
                state_d = ST_TRAIN;
            end
            ST_TRAIN: begin
                if (good_bc) begin
                    bc_cnt_d = bc_inc;
                end else if (link.rx_byte_valid) begin
                    bc_cnt_d = '0;
                end
                // An explicit request outranks lock and timeout here.
                if (link.retrain_req) begin
                    restart = 1'b1;
                end else if (good_bc && (bc_inc == LOCK_V)) begin
                    state_d = ST_ACTIVE;
                end else if (tmr_done) begin
                    state_d = ST_FAIL;
                end
            end
            ST_ACTIVE: begin
                if (err_byte) begin
                    err_cnt_d = err_inc;
                end else if (link.rx_byte_valid) begin
                    err_cnt_d = '0;
                end
                if (link.retrain_req || (err_byte && (err_inc == ERR_V))) begin
                    state_d = ST_RETRAIN;
                end
            end
            ST_RETRAIN: begin
                if (tmr_done) begin
                    state_d = ST_TRAIN;
                end
            end
            ST_FAIL: begin
                if (link.retrain_req || tmr_done) begin
                    state_d = ST_TRAIN;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase

        // Every entry (including a TRAIN restart) starts from clean counters.
        if ((state_d != state_q) || restart) begin
            bc_cnt_d  = '0;
            err_cnt_d = '0;
            tmr_load  = 1'b1;
            case (state_d)
                ST_TRAIN:   tmr_val = TMR_W'(TIMEOUT);
                ST_RETRAIN: tmr_val = TMR_W'(HOLD_CYC);
                ST_FAIL:    tmr_val = TMR_W'(RETRY_WAIT);
                default:    tmr_val = '0;
            endcase
            if ((state_d == ST_RETRAIN) && (retrain_cnt_q != 8'hFF)) begin
                retrain_cnt_d = retrain_cnt_q + 8'd1;
            end
        end

        // Outputs follow the state being entered so they line up with it.
        case (state_d)
            ST_ACTIVE: begin
                tx_enable_d  = link.tx_pending;
                tx_send_bc_d = !link.tx_pending;
                link_up_d    = 1'b1;
            end
            ST_FAIL: begin
                link_fail_d  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // FSM state, counters and registered outputs; reset acts immediately.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RST;
            bc_cnt_q      <= '0;
            err_cnt_q     <= '0;
            retrain_cnt_q <= '0;
            tx_send_bc_q  <= 1'b1;
            tx_enable_q   <= 1'b0;
            link_up_q     <= 1'b0;
            link_fail_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bc_cnt_q      <= bc_cnt_d;
            err_cnt_q     <= err_cnt_d;
            retrain_cnt_q <= retrain_cnt_d;
            tx_send_bc_q  <= tx_send_bc_d;
            tx_enable_q   <= tx_enable_d;
            link_up_q     <= link_up_d;
            link_fail_q   <= link_fail_d;
        end
    end

    assign link.state       = state_q;
    assign link.tx_send_bc  = tx_send_bc_q;
    assign link.tx_enable   = tx_enable_q;
    assign link.link_up     = link_up_q;
    assign link.link_fail   = link_fail_q;
    assign link.retrain_cnt = retrain_cnt_q;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Scoreboard bench for phy_link_ctrl: the driver steps a behavioural link
// model per cycle and queues the expected outputs; a monitor compares them.
module tb_phy_link_ctrl;

    localparam logic [7:0] BC    = 8'hBC;
    localparam int         LOCK  = 4;
    localparam int         TMO   = 255;
    localparam int         ERRM  = 4;
    localparam int         HOLD  = 8;
    localparam int         RETRY = 64;

    typedef struct packed {
        logic [2:0] st;
        logic       sbc;
        logic       en;
        logic       up;
        logic       fl;
        logic [7:0] rc;
    } out_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    bit   rst_lvl = 1'b0;

    phy_link_ctrl_if lif();

    phy_link_ctrl #(
        .BC_BYTE    (BC),
        .LOCK_CNT   (LOCK),
        .TIMEOUT    (TMO),
        .ERR_MAX    (ERRM),
        .HOLD_CYC   (HOLD),
        .RETRY_WAIT (RETRY)
    ) dut (
        .clk_4f (clk),
        .reset  (reset),
        .link   (lif)
    );

    always #5 clk = ~clk;

    out_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model: link mode (0 reset,1 train,2 active,3 retrain,4 fail) plus
    // plain up-counting cycle/byte counters per mode.
    int m_st, m_bc, m_tmo, m_err, m_hold, m_wait, m_rc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_clear();
        m_bc = 0; m_tmo = 0; m_err = 0; m_hold = 0; m_wait = 0;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_rc = 0;
        model_clear();
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] b, input bit e, input bit r);
        int  nxt;
        bit  again;
        nxt   = m_st;
        again = 1'b0;
        case (m_st)
            0: nxt = 1;
            1: begin
                m_tmo++;
                if (v) m_bc = (b == BC && !e) ? m_bc + 1 : 0;
                if (r)                  again = 1'b1;
                else if (m_bc == LOCK)  nxt = 2;
                else if (m_tmo == TMO)  nxt = 4;
            end
            2: begin
                if (v) m_err = e ? m_err + 1 : 0;
                if (r || m_err == ERRM) nxt = 3;
            end
            3: begin
                m_hold++;
                if (m_hold == HOLD) nxt = 1;
            end
            4: begin
                m_wait++;
                if (r || m_wait == RETRY) nxt = 1;
            end
            default: nxt = 0;
        endcase
        if (nxt != m_st || again) begin
            model_clear();
            if (nxt == 3 && m_rc < 255) m_rc++;
        end
        m_st = nxt;
    endfunction

    function automatic out_t model_out(input bit p);
        out_t o;
        o.st  = 3'(m_st);
        o.sbc = (m_st == 2) ? !p : 1'b1;
        o.en  = (m_st == 2) && p;
        o.up  = (m_st == 2);
        o.fl  = (m_st == 4);
        o.rc  = 8'(m_rc);
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.st  = lif.state;
        o.sbc = lif.tx_send_bc;
        o.en  = lif.tx_enable;
        o.up  = lif.link_up;
        o.fl  = lif.link_fail;
        o.rc  = lif.retrain_cnt;
        return o;
    endfunction

    // One clk_4f cycle of stimulus; its expected result is queued.
    task automatic cyc(input bit v, input logic [7:0] b, input bit e, input bit p, input bit r);
        @(negedge clk);
        reset             = rst_lvl;
        lif.rx_byte_valid = v;
        lif.rx_byte       = b;
        lif.rx_err        = e;
        lif.tx_pending    = p;
        lif.retrain_req   = r;
        if (!rst_lvl) model_reset();
        else          model_step(v, b, e, r);
        exp_q.push_back(model_out(p));
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    task automatic goto_train();
        for (int i = 0; i < 600 && m_st != 1; i++)
            cyc(1'b0, 8'h00, 1'b0, 1'b0, (m_st == 2 || m_st == 4));
        settle();
        chk("reach_train", 32'(lif.state), 32'd1);
    endtask

    task automatic lock_bytes(input bit p);
        repeat (LOCK) cyc(1'b1, BC, 1'b0, p, 1'b0);
    endtask

    task automatic rand_phase(input int n, input int err_mod);
        for (int i = 0; i < n; i++)
            cyc(($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) != 0) ? BC : 8'($urandom),
                ($urandom_range(0, err_mod - 1) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 49) == 0));
    endtask

    // Monitor: one expected output set per clock, checked after the edge.
    initial begin
        out_t ev;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                chk("outputs{st,sbc,en,up,fail,rc}", {17'd0, dut_out()}, {17'd0, ev});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        lif.rx_byte = 8'h00; lif.rx_byte_valid = 1'b0; lif.rx_err = 1'b0;
        lif.tx_pending = 1'b0; lif.retrain_req = 1'b0;
        model_reset();

        // Reset held, then release and lock on four clean BC bytes.
        rst_lvl = 1'b0;
        idle(2);
        rst_lvl = 1'b1;
        idle(1);
        cyc(1'b1, BC, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, BC, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, BC, 1'b0, 1'b1, 1'b0);
        settle();
        chk("lock_not_early", 32'(lif.link_up), 32'd0);
        cyc(1'b1, BC, 1'b0, 1'b0, 1'b0);
        settle();
        chk("lock_state", 32'(lif.state), 32'd2);
        for (int i = 0; i < 6; i++) cyc(1'b1, BC, 1'b0, 1'(i % 2), 1'b0);

        // Broken BC run: lock only after the 8th byte.
        cyc(1'b0, BC, 1'b0, 1'b0, 1'b1);
        goto_train();
        cyc(1'b1, BC, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, BC, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, BC, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, BC, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, BC, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, BC, 1'b0, 1'b0, 1'b0);
        settle();
        chk("bc_restart_7th", 32'(lif.state), 32'd1);
        cyc(1'b1, BC, 1'b0, 1'b1, 1'b0);
        settle();
        chk("bc_restart_8th", 32'(lif.state), 32'd2);

        // Error run 3 bad, 1 good, 4 bad: retrain only on the last.
        rc0 = int'(lif.retrain_cnt);
        repeat (3) cyc(1'b1, BC, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, BC, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, BC, 1'b1, 1'b0, 1'b0);
        settle();
        chk("err_not_early", 32'(lif.state), 32'd2);
        cyc(1'b1, BC, 1'b1, 1'b0, 1'b0);
        settle();
        chk("err_retrain", 32'(lif.state), 32'd3);
        chk("err_retrain_cnt", 32'(lif.retrain_cnt), 32'(rc0 + 1));
        idle(7);
        settle();
        chk("hold_7", 32'(lif.state), 32'd3);
        idle(1);
        settle();
        chk("hold_8", 32'(lif.state), 32'd1);

        // Timeout boundary, then the FAIL wait boundary.
        idle(TMO - 1);
        settle();
        chk("tmo_minus1", 32'(lif.state), 32'd1);
        idle(1);
        settle();
        chk("tmo_fail", 32'(lif.link_fail), 32'd1);
        idle(RETRY - 1);
        settle();
        chk("retry_minus1", 32'(lif.state), 32'd4);
        idle(1);
        settle();
        chk("retry_train", 32'(lif.state), 32'd1);
        chk("retry_fail_clr", 32'(lif.link_fail), 32'd0);

        // Error limit and request together: a single retrain entry.
        lock_bytes(1'b1);
        rc0 = int'(lif.retrain_cnt);
        repeat (3) cyc(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        settle();
        chk("dual_cause_cnt", 32'(lif.retrain_cnt), 32'(rc0 + 1));
        goto_train();

        // FAIL left early by request, without counting a retrain.
        idle(TMO);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        goto_train();

        // Retrain counter saturation.
        for (int i = 0; i < 300; i++) begin
            lock_bytes(1'($urandom_range(0, 1)));
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            goto_train();
        end
        chk("rc_saturate", 32'(lif.retrain_cnt), 32'd255);

        // Randomised traffic against the model.
        rand_phase(2000, 10);
        rand_phase(1500, 3);

        // Asynchronous reset in ACTIVE while data is pending.
        goto_train();
        lock_bytes(1'b1);
        cyc(1'b1, BC, 1'b0, 1'b1, 1'b0);
        settle();
        chk("pre_reset_en", 32'(lif.tx_enable), 32'd1);
        #4;
        reset   = 1'b0;
        rst_lvl = 1'b0;
        model_reset();
        #1;
        chk("async_en", 32'(lif.tx_enable), 32'd0);
        chk("async_up", 32'(lif.link_up), 32'd0);
        chk("async_sbc", 32'(lif.tx_send_bc), 32'd1);
        chk("async_state", 32'(lif.state), 32'd0);
        idle(2);
        rst_lvl = 1'b1;
        idle(1);
        rand_phase(300, 8);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
